// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M multiply/divide unit: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle, result held until ID accepts it.

package ibex_multdiv_pkg;
  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;
endpackage

module ibex_multdiv_iter
  import ibex_multdiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic        mult_sel_i,
  input  logic        div_sel_i,
  input  md_op_e      operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        data_ind_timing_i,
  input  logic        multdiv_ready_id_i,
  output logic        valid_o,
  output logic [31:0] multdiv_result_o
);

  typedef enum logic [2:0] {
    IDLE, ABS_A, ABS_B, COMP, CHANGE_SIGN, FINISH
  } md_state_e;

  md_state_e   state_q, state_d;
  // Multiply: 64-bit product. Divide: [63:32] remainder, [31:0] dividend
  // bits shifting out while quotient bits shift in.
  logic [63:0] acc_q, acc_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [4:0]  cnt_q, cnt_d;
  md_op_e      operator_q, operator_d;
  logic [1:0]  signed_mode_q, signed_mode_d;
  logic        mult_q, mult_d;
  logic        b_neg_q, b_neg_d;
  logic        b_zero_q, b_zero_d;

  logic        a_neg;
  logic [63:0] a_ext;
  logic [63:0] mul_addend;
  logic [63:0] mul_sum;
  logic        div_borrow;
  logic [31:0] div_rem;
  logic [31:0] mult_result;
  logic [31:0] div_result;

  assign a_neg = signed_mode_q[0] & op_a_q[31];
  assign a_ext = {{32{a_neg}}, op_a_q};

  // MSB-first Horner multiply; the sign bit of a signed multiplier carries
  // negative weight, so that single step subtracts instead of adding.
  assign mul_addend = op_b_q[cnt_q] ? a_ext : 64'd0;
  assign mul_sum    = (signed_mode_q[1] && cnt_q == 5'd31)
                    ? ({acc_q[62:0], 1'b0} - mul_addend)
                    : ({acc_q[62:0], 1'b0} + mul_addend);

  // Partial remainder {rem, next dividend bit} is < 2*divisor, so the
  // difference always fits back into 32 bits.
  assign div_borrow = acc_q[63:31] < {1'b0, op_b_q};
  assign div_rem    = acc_q[62:31] - op_b_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d       = state_q;
    acc_d         = acc_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    cnt_d         = cnt_q;
    operator_d    = operator_q;
    signed_mode_d = signed_mode_q;
    mult_d        = mult_q;
    b_neg_d       = b_neg_q;
    b_zero_d      = b_zero_q;

    unique case (state_q)
      IDLE: begin
        if (mult_en_i || div_en_i) begin
          op_a_d        = op_a_i;
          op_b_d        = op_b_i;
          operator_d    = operator_i;
          signed_mode_d = signed_mode_i;
          mult_d        = mult_en_i;
          b_neg_d       = signed_mode_i[1] & op_b_i[31];
          b_zero_d      = (op_b_i == 32'd0);
          cnt_d         = 5'd31;
          acc_d         = 64'd0;
          if (mult_en_i) begin
            state_d = COMP;
          end else if (op_b_i == 32'd0 && !data_ind_timing_i) begin
            acc_d   = {op_a_i, 32'hFFFF_FFFF};
            state_d = FINISH;
          end else begin
            state_d = ABS_A;
          end
        end
      end
      ABS_A: begin
        acc_d   = {32'd0, a_neg ? -op_a_q : op_a_q};
        state_d = ABS_B;
      end
      ABS_B: begin
        op_b_d  = b_neg_q ? -op_b_q : op_b_q;
        cnt_d   = 5'd31;
        state_d = COMP;
      end
      COMP: begin
        if (mult_q) begin
          acc_d = mul_sum;
        end else if (div_borrow) begin
          acc_d = {acc_q[62:0], 1'b0};
        end else begin
          acc_d = {div_rem, acc_q[30:0], 1'b1};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = mult_q ? FINISH : CHANGE_SIGN;
      end
      CHANGE_SIGN: begin
        // A zero divisor keeps the all-ones quotient regardless of signs.
        if ((a_neg ^ b_neg_q) && !b_zero_q) acc_d[31:0] = -acc_q[31:0];
        if (a_neg) acc_d[63:32] = -acc_q[63:32];
        state_d = FINISH;
      end
      FINISH: begin
        if (multdiv_ready_id_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !mult_en_i && !div_en_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      acc_q         <= 64'd0;
      op_a_q        <= 32'd0;
      op_b_q        <= 32'd0;
      cnt_q         <= 5'd0;
      operator_q    <= MD_OP_MULL;
      signed_mode_q <= 2'b00;
      mult_q        <= 1'b0;
      b_neg_q       <= 1'b0;
      b_zero_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      acc_q         <= acc_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      cnt_q         <= cnt_d;
      operator_q    <= operator_d;
      signed_mode_q <= signed_mode_d;
      mult_q        <= mult_d;
      b_neg_q       <= b_neg_d;
      b_zero_q      <= b_zero_d;
    end
  end

  assign valid_o     = (state_q == FINISH);
  assign mult_result = (operator_q == MD_OP_MULH) ? acc_q[63:32] : acc_q[31:0];
  assign div_result  = (operator_q == MD_OP_REM)  ? acc_q[63:32] : acc_q[31:0];

  always_comb begin
    multdiv_result_o = 32'd0;
    if (mult_sel_i)     multdiv_result_o = mult_result;
    else if (div_sel_i) multdiv_result_o = div_result;
  end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed + random bench for ibex_multdiv_iter: expected results and
// latencies are queued at issue time and compared when valid_o rises.

module tb_ibex_multdiv_iter;
  import ibex_multdiv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mult_en_i = 1'b0;
  logic        div_en_i = 1'b0;
  logic        mult_sel_i = 1'b0;
  logic        div_sel_i = 1'b0;
  md_op_e      operator_i = MD_OP_MULL;
  logic [1:0]  signed_mode_i = 2'b00;
  logic [31:0] op_a_i = 32'd0;
  logic [31:0] op_b_i = 32'd0;
  logic        data_ind_timing_i = 1'b0;
  logic        multdiv_ready_id_i = 1'b1;
  logic        valid_o;
  logic [31:0] multdiv_result_o;

  ibex_multdiv_iter dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .mult_en_i          (mult_en_i),
    .div_en_i           (div_en_i),
    .mult_sel_i         (mult_sel_i),
    .div_sel_i          (div_sel_i),
    .operator_i         (operator_i),
    .signed_mode_i      (signed_mode_i),
    .op_a_i             (op_a_i),
    .op_b_i             (op_b_i),
    .data_ind_timing_i  (data_ind_timing_i),
    .multdiv_ready_id_i (multdiv_ready_id_i),
    .valid_o            (valid_o),
    .multdiv_result_o   (multdiv_result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [31:0] result;
    int          latency;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input md_op_e op, input logic [1:0] sm,
                                       input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        xa, xb, p;
    logic signed [31:0] sa, sbv;
    xa  = sm[0] ? {{32{a[31]}}, a} : {32'd0, a};
    xb  = sm[1] ? {{32{b[31]}}, b} : {32'd0, b};
    p   = xa * xb;
    sa  = a;
    sbv = b;
    case (op)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      MD_OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (sm == 2'b11) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
          return sa / sbv;
        end
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (sm == 2'b11) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
          return sa % sbv;
        end
        return a % b;
      end
    endcase
  endfunction

  task automatic drive(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                       input logic [31:0] b, input logic dit);
    logic is_mult;
    is_mult = (op == MD_OP_MULL) || (op == MD_OP_MULH);
    @(negedge clk_i);
    mult_en_i         = is_mult;
    div_en_i          = !is_mult;
    mult_sel_i        = is_mult;
    div_sel_i         = !is_mult;
    operator_i        = op;
    signed_mode_i     = sm;
    op_a_i            = a;
    op_b_i            = b;
    data_ind_timing_i = dit;
  endtask

  // Waits for valid_o, compares against the scoreboard head, optionally
  // holds ready low for `hold` cycles, then releases the result.
  task automatic collect(input int hold);
    exp_t e;
    int   k;
    bit   seen;
    logic m_sel, d_sel;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 60) begin
      @(negedge clk_i);
      k++;
      seen = valid_o;
    end
    e = sb.pop_front();
    check({e.tag, "/valid"}, 32'(seen), 32'd1);
    if (seen) begin
      check({e.tag, "/latency"}, 32'(k), 32'(e.latency));
      check({e.tag, "/result"}, multdiv_result_o, e.result);
      for (int i = 1; i <= hold; i++) begin
        @(negedge clk_i);
        check($sformatf("%s/hold%0d_valid", e.tag, i), {31'd0, valid_o}, 32'd1);
        check($sformatf("%s/hold%0d_result", e.tag, i), multdiv_result_o, e.result);
        if (i == 2) begin
          m_sel      = mult_sel_i;
          d_sel      = div_sel_i;
          mult_sel_i = 1'b0;
          div_sel_i  = 1'b0;
          #1;
          check({e.tag, "/no_sel_zero"}, multdiv_result_o, 32'd0);
          mult_sel_i = m_sel;
          div_sel_i  = d_sel;
          #1;
        end
      end
    end
    multdiv_ready_id_i = 1'b1;
    mult_en_i          = 1'b0;
    div_en_i           = 1'b0;
    @(negedge clk_i);
    check({e.tag, "/released"}, {31'd0, valid_o}, 32'd0);
  endtask

  task automatic run(input string tag, input md_op_e op, input logic [1:0] sm,
                     input logic [31:0] a, input logic [31:0] b, input logic dit,
                     input logic [31:0] exp, input int hold);
    exp_t e;
    logic is_mult;
    is_mult   = (op == MD_OP_MULL) || (op == MD_OP_MULH);
    e.tag     = tag;
    e.result  = exp;
    e.latency = is_mult ? 33 : ((b == 32'd0 && !dit) ? 1 : 36);
    multdiv_ready_id_i = (hold == 0);
    drive(op, sm, a, b, dit);
    sb.push_back(e);
    collect(hold);
  endtask

  initial begin
    bit seen;

    mult_sel_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset/valid", {31'd0, valid_o}, 32'd0);
    check("reset/result", multdiv_result_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_reset/valid", {31'd0, valid_o}, 32'd0);

    run("mul_7x6",     MD_OP_MULL, 2'b00, 32'd7,          32'd6,          1'b0, 32'h0000_002A, 0);
    run("mulh_min",    MD_OP_MULH, 2'b11, 32'h8000_0000,  32'h8000_0000,  1'b0, 32'h4000_0000, 0);
    run("mulhu_min",   MD_OP_MULH, 2'b00, 32'h8000_0000,  32'h8000_0000,  1'b0, 32'h4000_0000, 0);
    run("mulhsu_m1",   MD_OP_MULH, 2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFF, 0);
    run("div_m7_2",    MD_OP_DIV,  2'b11, 32'hFFFF_FFF9,  32'd2,          1'b0, 32'hFFFF_FFFD, 0);
    run("rem_m7_2",    MD_OP_REM,  2'b11, 32'hFFFF_FFF9,  32'd2,          1'b0, 32'hFFFF_FFFF, 0);
    run("divu_100_7",  MD_OP_DIV,  2'b00, 32'd100,        32'd7,          1'b0, 32'd14,        0);
    run("remu_100_7",  MD_OP_REM,  2'b00, 32'd100,        32'd7,          1'b0, 32'd2,         0);
    run("div_zero_ee", MD_OP_DIV,  2'b11, 32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF, 0);
    run("rem_zero_dit",MD_OP_REM,  2'b11, 32'h1234_5678,  32'd0,          1'b1, 32'h1234_5678, 0);
    run("div_ovf",     MD_OP_DIV,  2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 0);
    run("rem_ovf",     MD_OP_REM,  2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,         0);
    run("mul_hold",    MD_OP_MULL, 2'b11, 32'hFFFF_FFFD,  32'd5,          1'b0, 32'hFFFF_FFF1, 5);
    run("div_hold",    MD_OP_DIV,  2'b00, 32'd1000,       32'd33,         1'b0, 32'd30,        5);

    // Kill: drop both enables in T10 of a divide; no result may appear.
    drive(MD_OP_DIV, 2'b00, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk_i);
    mult_en_i = 1'b0;
    div_en_i  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
    end
    check("kill/no_valid", 32'(seen), 32'd0);
    run("after_kill",  MD_OP_MULL, 2'b00, 32'd12345,      32'd1000,       1'b0, 32'd12345000,  0);

    // Reset in the middle of COMP clears outputs immediately.
    drive(MD_OP_MULL, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (10) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("rst_comp/valid", {31'd0, valid_o}, 32'd0);
    check("rst_comp/result", multdiv_result_o, 32'd0);
    @(negedge clk_i);
    mult_en_i = 1'b0;
    rst_ni    = 1'b1;
    @(negedge clk_i);
    check("rst_comp/idle", {31'd0, valid_o}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      md_op_e      op;
      logic [1:0]  sm;
      logic [31:0] a, b;
      logic        dit;
      op  = md_op_e'(2'($urandom_range(0, 3)));
      a   = $urandom;
      b   = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 6) b = 32'd0;
      dit = 1'($urandom_range(0, 1));
      if (op == MD_OP_DIV || op == MD_OP_REM) begin
        sm = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      end else begin
        case ($urandom_range(0, 2))
          0:       sm = 2'b00;
          1:       sm = 2'b01;
          default: sm = 2'b11;
        endcase
      end
      run($sformatf("rand%0d", i), op, sm, a, b, dit, model(op, sm, a, b), 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
